// File: rtl/pic_interrupt_sequencer_if.sv
// ---------------------------------------------------------------------------
// pic_interrupt_sequencer_if
// Register/vector bus between the 8259A read/write logic and the interrupt
// sequencer.
//   ICW1/ICW2/ICW4/OCW1/OCW2 : latched command words (rw logic -> sequencer)
//   OCW2_change, icw1_write  : one-cycle write strobes (rw logic -> sequencer)
//   vectorOut, vectorOutEn   : vector byte + bus drive enable (sequencer -> rw)
// master = read/write logic side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface pic_interrupt_sequencer_if;
    logic [7:0] ICW1;
    logic [7:0] ICW2;
    logic [7:0] ICW4;
    logic [7:0] OCW1;
    logic [7:0] OCW2;
    logic       OCW2_change;
    logic       icw1_write;
    logic [7:0] vectorOut;
    logic       vectorOutEn;

    modport master (
        output ICW1, ICW2, ICW4, OCW1, OCW2, OCW2_change, icw1_write,
        input  vectorOut, vectorOutEn
    );

    modport slave (
        input  ICW1, ICW2, ICW4, OCW1, OCW2, OCW2_change, icw1_write,
        output vectorOut, vectorOutEn
    );
endinterface

// File: rtl/pic_interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// pic_interrupt_sequencer
// Maintains IRR/ISR, resolves priority, drives INT and runs the two-pulse
// 8086-mode INTA sequence returning {ICW2[7:3], level} on the data bus.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   IR[7:0]    : external interrupt requests (active high, asynchronous)
//   INTA_n     : interrupt acknowledge from CPU (active low, asynchronous)
//   bus        : slave side of pic_interrupt_sequencer_if (command words,
//                write strobes, vectorOut/vectorOutEn)
//   INT        : registered interrupt request to the CPU
//   IRR, ISR   : interrupt request / in-service registers
//
// Parameter SYNC_STAGES (1..3): synchronizer depth on IR and INTA_n.
// Optional feature: define ROTATE_EN for the rotating lowest-priority
// pointer and the OCW2 rotate / set-priority commands.
// ---------------------------------------------------------------------------
module pic_interrupt_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                IR,
    input  logic                      INTA_n,
    pic_interrupt_sequencer_if.slave  bus,
    output logic                      INT,
    output logic [7:0]                IRR,
    output logic [7:0]                ISR
);

    typedef enum logic [1:0] {IDLE, INTA1, GAP, INTA2} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0][7:0] ir_sync;
    logic [SYNC_STAGES-1:0]      inta_sync;
    logic [7:0]                  ir_s, ir_prev;
    logic                        inta_s, inta_prev;
    logic                        inta_fall, inta_rise;

    logic [2:0] prio_ptr;       // lowest-priority level
    logic [3:0] req;            // {found, level} of highest unmasked request
    logic [3:0] top;            // {found, level} of highest in-service level
    logic       eligible;
    logic       ack;            // INTA1 entry this cycle
    logic       seq_done;       // INTA2 exit this cycle
    logic [2:0] lvl_q;
    logic       spurious_q;
    logic [7:0] set_mask, clr_mask, isr_n, irr_n;
`ifdef ROTATE_EN
    logic [2:0] ptr_n;
`endif

    // Highest-priority set bit of v with p as the lowest-priority level.
    // Scans from lowest to highest so the last hit is the winner.
    function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] p);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'd1 + 3'(i);
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // 0 = highest priority.
    function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] p);
        return lvl - p - 3'd1;
    endfunction

    // INTA_n chain resets to its inactive (high) level so leaving reset
    // never looks like an acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_sync   <= '0;
            inta_sync <= '1;
        end else begin
            ir_sync[0]   <= IR;
            inta_sync[0] <= INTA_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ir_sync[i]   <= ir_sync[i-1];
                inta_sync[i] <= inta_sync[i-1];
            end
        end
    end

    assign ir_s      = ir_sync[SYNC_STAGES-1];
    assign inta_s    = inta_sync[SYNC_STAGES-1];
    assign inta_fall = inta_prev & ~inta_s;
    assign inta_rise = ~inta_prev & inta_s;

`ifndef ROTATE_EN
    assign prio_ptr = 3'd7;
`endif

    assign req      = pick(IRR & ~bus.OCW1, prio_ptr);
    assign top      = pick(ISR, prio_ptr);
    assign eligible = req[3] && (!top[3] || (rank(req[2:0], prio_ptr) < rank(top[2:0], prio_ptr)));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              state <= IDLE;
        else if (bus.icw1_write) state <= IDLE;
        else                     state <= state_n;
    end

    // FSM next state and vector outputs
    always_comb begin
        state_n         = state;
        ack             = 1'b0;
        seq_done        = 1'b0;
        bus.vectorOut   = 8'h00;
        bus.vectorOutEn = 1'b0;
        case (state)
            IDLE:  if (inta_fall) begin state_n = INTA1; ack = 1'b1; end
            INTA1: if (inta_rise) state_n = GAP;
            GAP:   if (inta_fall) state_n = INTA2;
            INTA2: begin
                bus.vectorOut   = {bus.ICW2[7:3], lvl_q};
                bus.vectorOutEn = 1'b1;
                if (inta_rise) begin
                    state_n  = IDLE;
                    seq_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // IRR / ISR next values. Set beats any same-cycle EOI clear on ISR;
    // the acknowledge clear beats a same-cycle edge on IRR.
    always_comb begin
        set_mask = (ack && eligible) ? (8'b1 << req[2:0]) : 8'b0;
        clr_mask = 8'b0;
`ifdef ROTATE_EN
        ptr_n    = prio_ptr;
`endif
        if (seq_done && bus.ICW4[1] && !spurious_q)
            clr_mask = clr_mask | (8'b1 << lvl_q);
        if (bus.OCW2_change) begin
            case (bus.OCW2[7:5])
                3'b001: if (top[3]) clr_mask = clr_mask | (8'b1 << top[2:0]);
                3'b011: clr_mask = clr_mask | (8'b1 << bus.OCW2[2:0]);
`ifdef ROTATE_EN
                3'b101: if (top[3]) begin
                    clr_mask = clr_mask | (8'b1 << top[2:0]);
                    ptr_n    = top[2:0];
                end
                3'b111: begin
                    clr_mask = clr_mask | (8'b1 << bus.OCW2[2:0]);
                    ptr_n    = bus.OCW2[2:0];
                end
                3'b110: ptr_n = bus.OCW2[2:0];
`endif
                default: ;
            endcase
        end
        isr_n = (ISR & ~clr_mask) | set_mask;
        // Level mode tracks the line, so an acknowledge clear on a line
        // that is still high is naturally ignored.
        irr_n = bus.ICW1[3] ? ir_s : ((IRR | (ir_s & ~ir_prev)) & ~set_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IRR        <= 8'h00;
            ISR        <= 8'h00;
            INT        <= 1'b0;
            lvl_q      <= 3'd7;
            spurious_q <= 1'b0;
            ir_prev    <= 8'h00;
            inta_prev  <= 1'b1;
        end else if (bus.icw1_write) begin
            IRR        <= 8'h00;
            ISR        <= 8'h00;
            INT        <= 1'b0;
            lvl_q      <= 3'd7;
            spurious_q <= 1'b0;
            ir_prev    <= ir_s;    // no false edge from lines already high
            inta_prev  <= inta_s;
        end else begin
            IRR       <= irr_n;
            ISR       <= isr_n;
            INT       <= (state == IDLE && !inta_fall) ? eligible : 1'b0;
            ir_prev   <= ir_s;
            inta_prev <= inta_s;
            if (ack) begin
                lvl_q      <= eligible ? req[2:0] : 3'd7;
                spurious_q <= !eligible;
            end
        end
    end

`ifdef ROTATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              prio_ptr <= 3'd7;
        else if (bus.icw1_write) prio_ptr <= 3'd7;
        else                     prio_ptr <= ptr_n;
    end
`endif

endmodule

// File: doc/pic_interrupt_sequencer.md
Name: pic_interrupt_sequencer

Overview:
Downstream consumer of the 8259A read/write logic. It takes the latched ICW1/ICW2/ICW4/OCW1/OCW2 registers and the external IR[7:0] lines, and maintains the IRR and ISR. It resolves priority, drives INT, and runs the two-pulse 8086-mode INTA sequence that returns the interrupt vector to the data bus buffer.

Parameters:
SYNC_STAGES, 2, flip-flop stages on the IR[7:0] and INTA_n inputs before any use (legal values 1..3).

Ports:
clk  input  1  single system clock
rst_n  input  1  asynchronous, active-low reset
IR  input  8  external interrupt request lines, active high
INTA_n  input  1  interrupt acknowledge from CPU, active low
ICW1  input  8  bit3 LTIM: 1 = level-triggered, 0 = edge-triggered
ICW2  input  8  bits[7:3] = vector base T7..T3
ICW4  input  8  bit1 AEOI
OCW1  input  8  IMR; bit n = 1 masks IRn
OCW2  input  8  EOI command byte
OCW2_change  input  1  one-cycle pulse when OCW2 is written
icw1_write  input  1  one-cycle pulse when ICW1 is written (init start)
INT  output  1  interrupt request to CPU, registered
vectorOut  output  8  vector byte for the data bus buffer
vectorOutEn  output  1  high while vectorOut must drive the bus
IRR  output  8  interrupt request register
ISR  output  8  in-service register

Behaviour:
- Reset (async, rst_n=0): IRR=0, ISR=0, INT=0, vectorOut=0x00, vectorOutEn=0, FSM=IDLE, synchronizers and edge-detect history cleared. Outputs take these values immediately, not at the next edge.
- icw1_write: synchronous. Same clear as reset, except the synchronizer chains are not cleared. Edge history is loaded from the current synced IR so no false edge is seen. Aborts any INTA sequence.
- Priority: fixed, IR0 highest, IR7 lowest, unless ROTATE_EN applies.
- Edge mode (LTIM=0): IRR[n] is set the cycle after a synced 0->1 transition on IRn. It is cleared at INTA1 entry when n is the acknowledged level.
- Level mode (LTIM=1): IRR[n] = synced IRn every cycle. At INTA1, if the acknowledged line is still high, the clear is ignored.
- Eligible request: highest-priority bit of (IRR & ~IMR). It must be strictly higher priority than the highest set ISR bit; if ISR=0, any eligible bit qualifies.
- INT: registered. Set 1 cycle after an eligible request exists while FSM=IDLE. Cleared on INTA1 entry. Re-evaluated on return to IDLE.
- FSM states:
  - IDLE -> INTA1 on a synced INTA_n falling edge. At entry: latch level L = eligible request; set ISR[L]; clear IRR[L].
  - No eligible request at INTA1 entry (spurious): L=7, ISR unchanged.
  - INTA1 -> GAP on synced INTA_n rising edge.
  - GAP -> INTA2 on synced INTA_n falling edge.
  - INTA2: vectorOut = {ICW2[7:3], L}, vectorOutEn=1.
  - INTA2 -> IDLE on rising edge. vectorOutEn=0 the same cycle IDLE is entered.
  - If AEOI=1 and not spurious, ISR[L] is cleared on INTA2 exit.
- EOI on OCW2_change:
  - OCW2[7:5]=001, non-specific: clear highest-priority set ISR bit. No-op if ISR=0.
  - OCW2[7:5]=011, specific: clear ISR[OCW2[2:0]].
  - Other codes: ignored, except where ROTATE_EN applies.
- Simultaneous events:
  - EOI clear and INTA1 set on the same ISR bit in one cycle: set wins.
  - IR edge on bit L in the INTA1-entry cycle: clear wins; the edge is consumed.
  - Edges on other bits set normally.
- Reset or icw1_write during GAP/INTA2: vectorOutEn drops at once (reset) or the next cycle (icw1_write).
- Mask change during a sequence does not alter the latched L.

Optional Feature:
ROTATE_EN.
- Defined: adds a 3-bit lowest-priority pointer P, reset to 7, cleared to 7 by icw1_write. Priority order is P+1 (highest) ... P, modulo 8. Extra OCW2 codes:
  - 101: rotate on non-specific EOI; clears highest-priority ISR bit k, then P=k.
  - 111: rotate on specific EOI; clears ISR[OCW2[2:0]], then P=OCW2[2:0].
  - 110: set priority; P=OCW2[2:0], no ISR change.
  - AEOI with rotation is not supported.
- Undefined: fixed priority; codes 101/110/111 ignored.

Test Plan:
1. ICW1=0x11, ICW2=0x40, ICW4=0x01, OCW1=0x00; pulse IR3 -> IRR=0x08, INT=1. Two INTA_n pulses -> vectorOutEn=1 in INTA2, vectorOut=0x43; after sequence ISR=0x08, IRR=0x00, INT=0.
2. OCW1=0x08; pulse IR3 -> IRR=0x08, INT stays 0. Write OCW1=0x00 -> INT=1 within 2 cycles.
3. ISR=0x08; raise IR5 -> INT=0. Raise IR1 -> INT=1; INTA pair -> vectorOut=0x41, ISR=0x0A. OCW2=0x20 -> ISR=0x08. OCW2=0x63 -> ISR=0x00.
4. ICW4=0x03 (AEOI); IR6 plus INTA pair -> vectorOut=0x46, ISR=0x00 after INTA2 exit. INTA pair with IRR=0 -> vectorOut=0x47, ISR unchanged.
5. Assert rst_n=0 during INTA2 -> vectorOutEn, INT, IRR, ISR all 0 immediately. icw1_write during GAP -> FSM IDLE, ISR=0.
6. (ROTATE_EN) ISR=0x04; OCW2=0xA0 -> ISR=0x00, P=2. Raise IR2 and IR3 together -> INTA yields vectorOut=0x43 first.
